mem_system_pipe: RTL and testbench
==================================

// Module: mem_system_pipe
// PURPOSE
//  Handshaked, registered successor to the combinational ROM/RAM memory system.
//  Decodes a 32-bit MIPS-style address into a ROM (text) region and a RAM (data) region.
//  Adds request/valid handshake, programmable RAM wait states, alignment and range checking.
//  Supports optional sub-word (byte/half) access. Sits between the core's load/store unit and the memory arrays.
// PARAMETERS
//  MEMORY_DEPTH  64             words per region (ROM and RAM each); power of 2, >=2
//  DATA_WIDTH    32             word width in bits; fixed at 32 (byte-lane logic is 4 lanes)
//  ROM_BASE      32'h0040_0000  byte base address of ROM region
//  RAM_BASE      32'h1001_0000  byte base address of RAM region
//  WAIT_STATES   0              extra cycles per RAM access (0..15); ROM always 0
// PORTS
//  CLK             in   1           clock, rising edge
//  RST             in   1           asynchronous reset, active-high
//  Req_i           in   1           request strobe; sampled only while Ready_o=1
//  Write_Enable_i  in   1           1=store, 0=load
//  Size_i          in   2           00 byte, 01 half, 10 word, 11 reserved (error)
//  Address_i       in   32          byte address
//  Write_Data      in   DATA_WIDTH  store data, right-aligned for sub-word
//  Ready_o         out  1           block idle, can accept Req_i
//  Valid_o         out  1           one-cycle response pulse
//  Read_Data       out  DATA_WIDTH  load result, valid while Valid_o=1
//  Error_o         out  1           access faulted; qualified by Valid_o
// BEHAVIOUR
//  - Reset: state IDLE, Ready_o=1, Valid_o=0, Read_Data=0, Error_o=0, wait counter=0.
//    RAM/ROM contents are not cleared.
//  - RST mid-access aborts the access. A pending store does not commit unless the commit edge
//    occurred before RST asserted.
//  - FSM IDLE -> (Req_i) ACCESS -> RESP -> IDLE.
//    - Req_i is accepted on the edge where Ready_o=1; Address/data/size/we are captured on that edge.
//    - ACCESS holds for WAIT_STATES cycles on a RAM hit. ROM hits and faults leave after 1 cycle.
//    - RESP: Valid_o=1, Ready_o=0, exactly one cycle.
//    - Latency from accept edge to Valid_o high is 2+WAIT_STATES cycles (RAM) or 2 cycles (ROM/fault).
//    - Throughput: one access per 3+WAIT_STATES cycles.
//  - Decode: hit when BASE <= addr < BASE + MEMORY_DEPTH*4.
//    Word index = addr[$clog2(MEMORY_DEPTH)+1:2] - base index.
//  - Fault conditions; any one sets Error_o=1 with Read_Data=0 and no memory change:
//    - no region hit;
//    - store to ROM;
//    - Size_i=11;
//    - misalignment: half with addr[0]=1, word with addr[1:0]!=0.
//  - Commit: the RAM write and the Read_Data register load occur on the ACCESS->RESP edge.
//    Reads see pre-write data (no same-access forwarding).
//  - Store response: Valid_o=1, Error_o=0, Read_Data=0.
//  - Wait counter counts down from WAIT_STATES and does not wrap. A Req_i outside IDLE is ignored.
//  - The highest address of a region (BASE+DEPTH*4-4) is valid. BASE+DEPTH*4 faults.
// CONFIGURATION
//  MEM_SUBWORD_EN defined:
//    - byte store writes lane addr[1:0] only; half store writes lanes {addr[1],0..1};
//    - byte/half loads return the selected lane right-aligned, zero-extended.
//  MEM_SUBWORD_EN undefined:
//    - Size_i is ignored and every access is a word;
//    - addr[1:0]!=0 faults.
// TESTING
//  1 Reset then idle: RST pulse mid-cycle -> Ready_o=1, Valid_o=0, Read_Data=0 asynchronously.
//  2 ROM load 0x0040_0004 with ROM word1=0xDEADBEEF -> Valid_o 2 cycles after accept,
//    Read_Data=0xDEADBEEF, Error_o=0.
//  3 WAIT_STATES=3: word store 0x1234_5678 @0x1001_0008, then load @0x1001_0008
//    -> load Valid_o 5 cycles after accept, data 0x1234_5678.
//  4 Faults: store to 0x0040_0000; load 0x1001_0100 (DEPTH=64); word load 0x1001_0002
//    -> Error_o=1, Read_Data=0, RAM unchanged.
//  5 MEM_SUBWORD_EN: word 0x1122_3344 @0x1001_0000, byte store 0xAA @0x1001_0001
//    -> word 0x1122_AA44; half load @0x1001_0002 -> 0x0000_1122.
//  6 RST asserted during ACCESS of a RAM store (WAIT_STATES=2) -> location unchanged,
//    no Valid_o, Ready_o=1 after RST.

Source files
------------

// File: rtl/mem_system_pipe.sv
// mem_system_pipe
//   Handshaked, registered ROM/RAM memory system for a MIPS-style load/store
//   unit. A request is captured in IDLE, decoded and executed in ACCESS
//   (held for WAIT_STATES extra cycles on a good RAM access), and answered
//   with a one-cycle Valid_o pulse in RESP.
//
//   Optional feature: define MEM_SUBWORD_EN to enable byte/half accesses.
//   Without it Size_i is ignored, every access is a word and any address
//   with addr[1:0] != 0 faults.
//
// Ports
//   CLK            in   clock, rising edge
//   RST            in   asynchronous reset, active-high
//   Req_i          in   request strobe, sampled only while Ready_o=1
//   Write_Enable_i in   1=store, 0=load
//   Size_i         in   00 byte, 01 half, 10 word, 11 reserved (faults)
//   Address_i      in   byte address
//   Write_Data     in   store data, right-aligned for sub-word stores
//   Ready_o        out  idle, can accept Req_i
//   Valid_o        out  one-cycle response pulse
//   Read_Data      out  load result (zero for stores and faults)
//   Error_o        out  access faulted, qualified by Valid_o
//
// ROM contents come from the ROM_IMAGE parameter (word i at bits [32*i +: 32]).
module mem_system_pipe #(
  parameter int                                 MEMORY_DEPTH = 64,
  parameter int                                 DATA_WIDTH   = 32,
  parameter logic [31:0]                        ROM_BASE     = 32'h0040_0000,
  parameter logic [31:0]                        RAM_BASE     = 32'h1001_0000,
  parameter int                                 WAIT_STATES  = 0,
  parameter logic [MEMORY_DEPTH*DATA_WIDTH-1:0] ROM_IMAGE    = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req_i,
  input  logic                  Write_Enable_i,
  input  logic [1:0]            Size_i,
  input  logic [31:0]           Address_i,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic                  Ready_o,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  Error_o
);

  localparam int                IDX_W    = $clog2(MEMORY_DEPTH);
  localparam logic [32:0]       ROM_END  = {1'b0, ROM_BASE} + 33'(MEMORY_DEPTH * 4);
  localparam logic [32:0]       RAM_END  = {1'b0, RAM_BASE} + 33'(MEMORY_DEPTH * 4);
  localparam logic [IDX_W-1:0]  ROM_BIDX = ROM_BASE[IDX_W+1:2];
  localparam logic [IDX_W-1:0]  RAM_BIDX = RAM_BASE[IDX_W+1:2];

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state, next_state;
  logic [3:0]              wait_cnt, next_cnt;
  logic                    accept, commit;
  logic                    err_q;

  logic [31:0]             addr_p0;
  logic [DATA_WIDTH-1:0]   wdata_p0;
  logic                    we_p0;
`ifdef MEM_SUBWORD_EN
  logic [1:0]              size_p0;
`endif

  logic [DATA_WIDTH-1:0]   ram [MEMORY_DEPTH];
  logic                    rom_hit, ram_hit, fault, ram_ok, misalign, size_err;
  logic [IDX_W-1:0]        rom_idx, ram_idx;
  logic [DATA_WIDTH-1:0]   sel_word, load_data, wlanes;
  logic [3:0]              be;

  assign accept  = (state == IDLE) && Req_i;
  assign Ready_o = (state == IDLE);
  assign Valid_o = (state == RESP);
  assign Error_o = Valid_o && err_q;

  // Stage p0: request capture on the accept edge (data only, no reset)
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_p0  <= Address_i;
      wdata_p0 <= Write_Data;
      we_p0    <= Write_Enable_i;
`ifdef MEM_SUBWORD_EN
      size_p0  <= Size_i;
`endif
    end
  end

  // Decode of the captured request, evaluated during ACCESS
  assign rom_hit  = ({1'b0, addr_p0} >= {1'b0, ROM_BASE}) && ({1'b0, addr_p0} < ROM_END);
  assign ram_hit  = ({1'b0, addr_p0} >= {1'b0, RAM_BASE}) && ({1'b0, addr_p0} < RAM_END);
  assign rom_idx  = addr_p0[IDX_W+1:2] - ROM_BIDX;
  assign ram_idx  = addr_p0[IDX_W+1:2] - RAM_BIDX;
  assign sel_word = ram_hit ? ram[ram_idx] : ROM_IMAGE[int'(rom_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign fault    = (!rom_hit && !ram_hit) || (rom_hit && we_p0) || size_err || misalign;
  assign ram_ok   = ram_hit && !fault;

`ifdef MEM_SUBWORD_EN
  // Sub-word stores replicate the data across lanes and let be[] pick the
  // target lane(s); loads shift the selected lane down and zero-extend.
  always_comb begin
    be        = 4'b1111;
    wlanes    = wdata_p0;
    misalign  = 1'b0;
    size_err  = 1'b0;
    load_data = sel_word;
    case (size_p0)
      2'b00: begin
        be        = 4'b0001 << addr_p0[1:0];
        wlanes    = {4{wdata_p0[7:0]}};
        load_data = {24'h0, sel_word[{addr_p0[1:0], 3'b000} +: 8]};
      end
      2'b01: begin
        be        = addr_p0[1] ? 4'b1100 : 4'b0011;
        wlanes    = {2{wdata_p0[15:0]}};
        misalign  = addr_p0[0];
        load_data = {16'h0, sel_word[{addr_p0[1], 4'b0000} +: 16]};
      end
      2'b10:   misalign = |addr_p0[1:0];
      default: size_err = 1'b1;
    endcase
  end
`else
  always_comb begin
    be        = 4'b1111;
    wlanes    = wdata_p0;
    misalign  = |addr_p0[1:0];
    size_err  = 1'b0;
    load_data = sel_word;
  end

  // Size_i has no effect when sub-word access is compiled out.
  logic unused_size;
  assign unused_size = ^Size_i;
`endif

  // Control: state and wait counter
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (Req_i) begin
          next_state = ACCESS;
          next_cnt   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        // Only a good RAM access pays wait states; ROM hits and faults finish at once.
        if (ram_ok && (wait_cnt != 4'd0)) begin
          next_cnt = wait_cnt - 4'd1;
        end else begin
          next_state = RESP;
          commit     = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stage p1: commit edge (ACCESS->RESP) loads the response registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      Read_Data <= '0;
      err_q     <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      if (commit) begin
        Read_Data <= (fault || we_p0) ? '0 : load_data;
        err_q     <= fault;
      end
    end
  end

  // RAM write on the same commit edge; an async reset before that edge
  // returns the FSM to IDLE, so an aborted store never reaches here.
  always_ff @(posedge CLK) begin
    if (commit && ram_ok && we_p0) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) ram[ram_idx][8*l +: 8] <= wlanes[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_system_pipe.sv
// tb_mem_system_pipe
//   Directed bench for mem_system_pipe with WAIT_STATES=3, MEMORY_DEPTH=64.
//   Latency is counted in rising edges from the accept edge (inclusive) to
//   the edge after which Valid_o is high: 2+WAIT_STATES for good RAM
//   accesses, 2 for ROM hits and faults.
module tb_mem_system_pipe;

  localparam int          WS  = 3;
  localparam int          LR  = 2 + WS;
  localparam int          LF  = 2;
  localparam logic [64*32-1:0] ROM_IMG = {32'hCAFE_0001, {61{32'h0}}, 32'hDEAD_BEEF, 32'h0BAD_F00D};

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Req_i = 1'b0;
  logic        Write_Enable_i = 1'b0;
  logic [1:0]  Size_i = 2'b10;
  logic [31:0] Address_i = '0;
  logic [31:0] Write_Data = '0;
  logic        Ready_o, Valid_o, Error_o;
  logic [31:0] Read_Data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_system_pipe #(
    .MEMORY_DEPTH(64),
    .DATA_WIDTH  (32),
    .ROM_BASE    (32'h0040_0000),
    .RAM_BASE    (32'h1001_0000),
    .WAIT_STATES (WS),
    .ROM_IMAGE   (ROM_IMG)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Req_i         (Req_i),
    .Write_Enable_i(Write_Enable_i),
    .Size_i        (Size_i),
    .Address_i     (Address_i),
    .Write_Data    (Write_Data),
    .Ready_o       (Ready_o),
    .Valid_o       (Valid_o),
    .Read_Data     (Read_Data),
    .Error_o       (Error_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    @(negedge CLK);
    Req_i = 1'b1; Write_Enable_i = we; Size_i = sz; Address_i = addr; Write_Data = wd;
    while (!got && lat < 40) begin
      @(posedge CLK);
      lat++;
      #1;
      Req_i = 1'b0;
      if (Valid_o) begin
        got = 1'b1;
        rd  = Read_Data;
        er  = Error_o;
      end
    end
    if (!got) begin
      check("timeout", 32'(got), 32'd1);
    end else begin
      @(posedge CLK); #1;
      check("valid_pulse", 32'(Valid_o), 32'd0);
      check("ready_back", 32'(Ready_o), 32'd1);
    end
  endtask

  task automatic xfer(input string tag, input logic we, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_access(we, sz, addr, wd, rd, er, lat);
    check({tag, "_lat"},  32'(lat), 32'(exp_lat));
    check({tag, "_data"}, rd, exp_rd);
    check({tag, "_err"},  32'(er), 32'(exp_er));
  endtask

  initial begin
    int nv;

    // Asynchronous reset before any clock edge
    #1 RST = 1'b1;
    #1;
    check("rst_ready", 32'(Ready_o), 32'd1);
    check("rst_valid", 32'(Valid_o), 32'd0);
    check("rst_rdata", Read_Data, 32'd0);
    check("rst_err",   32'(Error_o), 32'd0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    // ROM loads, including the top word, and the first address past ROM
    xfer("rom_w1",  1'b0, 2'b10, 32'h0040_0004, 32'h0, LF, 32'hDEAD_BEEF, 1'b0);
    xfer("rom_w0",  1'b0, 2'b10, 32'h0040_0000, 32'h0, LF, 32'h0BAD_F00D, 1'b0);
    xfer("rom_top", 1'b0, 2'b10, 32'h0040_00FC, 32'h0, LF, 32'hCAFE_0001, 1'b0);
    xfer("rom_end", 1'b0, 2'b10, 32'h0040_0100, 32'h0, LF, 32'h0, 1'b1);

    // Reset asserted mid-cycle while the response is being presented
    @(negedge CLK);
    Req_i = 1'b1; Write_Enable_i = 1'b0; Size_i = 2'b10; Address_i = 32'h0040_0004;
    @(posedge CLK); #1; Req_i = 1'b0;
    @(posedge CLK); #1;
    check("resp_valid", 32'(Valid_o), 32'd1);
    check("resp_data",  Read_Data, 32'hDEAD_BEEF);
    #2 RST = 1'b1;
    #1;
    check("midrst_ready", 32'(Ready_o), 32'd1);
    check("midrst_valid", 32'(Valid_o), 32'd0);
    check("midrst_rdata", Read_Data, 32'd0);
    check("midrst_err",   32'(Error_o), 32'd0);
    @(negedge CLK); RST = 1'b0;

    // RAM word store/load with wait states, and the top RAM word
    xfer("ram_st8",  1'b1, 2'b10, 32'h1001_0008, 32'h1234_5678, LR, 32'h0, 1'b0);
    xfer("ram_ld8",  1'b0, 2'b10, 32'h1001_0008, 32'h0, LR, 32'h1234_5678, 1'b0);
    xfer("ram_stfc", 1'b1, 2'b10, 32'h1001_00FC, 32'h0F0F_1234, LR, 32'h0, 1'b0);
    xfer("ram_ldfc", 1'b0, 2'b10, 32'h1001_00FC, 32'h0, LR, 32'h0F0F_1234, 1'b0);

    // Faults
    xfer("st_rom",   1'b1, 2'b10, 32'h0040_0000, 32'hFFFF_FFFF, LF, 32'h0, 1'b1);
    xfer("rom_keep", 1'b0, 2'b10, 32'h0040_0000, 32'h0, LF, 32'h0BAD_F00D, 1'b0);
    xfer("ram_end",  1'b0, 2'b10, 32'h1001_0100, 32'h0, LF, 32'h0, 1'b1);
    xfer("ram_mis",  1'b0, 2'b10, 32'h1001_0002, 32'h0, LF, 32'h0, 1'b1);
    xfer("ram_low",  1'b0, 2'b10, 32'h1000_FFFC, 32'h0, LF, 32'h0, 1'b1);
    xfer("st_mis",   1'b1, 2'b10, 32'h1001_0009, 32'hFFFF_FFFF, LF, 32'h0, 1'b1);
    xfer("ram_keep", 1'b0, 2'b10, 32'h1001_0008, 32'h0, LR, 32'h1234_5678, 1'b0);
`ifdef MEM_SUBWORD_EN
    xfer("size11",   1'b0, 2'b11, 32'h1001_0008, 32'h0, LF, 32'h0, 1'b1);
`else
    xfer("size11",   1'b0, 2'b11, 32'h1001_0008, 32'h0, LR, 32'h1234_5678, 1'b0);
`endif

    // Sub-word access
    xfer("sw_word",  1'b1, 2'b10, 32'h1001_0000, 32'h1122_3344, LR, 32'h0, 1'b0);
`ifdef MEM_SUBWORD_EN
    xfer("sb_st1",   1'b1, 2'b00, 32'h1001_0001, 32'h0000_00AA, LR, 32'h0, 1'b0);
    xfer("sb_word",  1'b0, 2'b10, 32'h1001_0000, 32'h0, LR, 32'h1122_AA44, 1'b0);
    xfer("sh_ld2",   1'b0, 2'b01, 32'h1001_0002, 32'h0, LR, 32'h0000_1122, 1'b0);
    xfer("sb_ld3",   1'b0, 2'b00, 32'h1001_0003, 32'h0, LR, 32'h0000_0011, 1'b0);
    xfer("sh_st2",   1'b1, 2'b01, 32'h1001_0002, 32'h0000_BEEF, LR, 32'h0, 1'b0);
    xfer("sh_word",  1'b0, 2'b10, 32'h1001_0000, 32'h0, LR, 32'hBEEF_AA44, 1'b0);
    xfer("sh_mis",   1'b0, 2'b01, 32'h1001_0001, 32'h0, LF, 32'h0, 1'b1);
`else
    xfer("sb_st1",   1'b1, 2'b00, 32'h1001_0001, 32'h0000_00AA, LF, 32'h0, 1'b1);
    xfer("sb_word",  1'b0, 2'b00, 32'h1001_0000, 32'h0, LR, 32'h1122_3344, 1'b0);
`endif

    // A request presented while busy is ignored
    xfer("busy_init", 1'b1, 2'b10, 32'h1001_0010, 32'h0, LR, 32'h0, 1'b0);
    @(negedge CLK);
    Req_i = 1'b1; Write_Enable_i = 1'b0; Size_i = 2'b10; Address_i = 32'h0040_0004; Write_Data = '0;
    @(posedge CLK); #1;
    Write_Enable_i = 1'b1; Address_i = 32'h1001_0010; Write_Data = 32'h0000_0055;
    @(posedge CLK); #1;
    check("busy_valid", 32'(Valid_o), 32'd1);
    check("busy_data",  Read_Data, 32'hDEAD_BEEF);
    Req_i = 1'b0;
    @(posedge CLK); #1;
    check("busy_idle",  32'(Ready_o), 32'd1);
    xfer("busy_ram",  1'b0, 2'b10, 32'h1001_0010, 32'h0, LR, 32'h0, 1'b0);

    // Reset during the ACCESS phase of a RAM store aborts it
    xfer("abort_init", 1'b1, 2'b10, 32'h1001_000C, 32'hA5A5_A5A5, LR, 32'h0, 1'b0);
    @(negedge CLK);
    Req_i = 1'b1; Write_Enable_i = 1'b1; Size_i = 2'b10; Address_i = 32'h1001_000C;
    Write_Data = 32'h0BAD_0000;
    @(posedge CLK); #1; Req_i = 1'b0;
    @(posedge CLK); #1;
    check("abort_busy", 32'(Ready_o), 32'd0);
    #2 RST = 1'b1;
    #1;
    check("abort_ready", 32'(Ready_o), 32'd1);
    check("abort_valid", 32'(Valid_o), 32'd0);
    @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (Valid_o) nv++;
    end
    check("abort_novalid", 32'(nv), 32'd0);
    check("abort_idle",    32'(Ready_o), 32'd1);
    xfer("abort_keep", 1'b0, 2'b10, 32'h1001_000C, 32'h0, LR, 32'hA5A5_A5A5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
